// File: rtl/bus_requester.sv
// Bus requester: raises req on a start edge, waits (bounded) for gnt, streams
// len single-cycle beats while granted, then drops req for one release cycle.
module bus_requester #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             gnt,
    output logic             req,
    output logic             busy,
    output logic             xfer_valid,
    output logic [LEN_W-1:0] xfer_idx,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_start_q;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] w_idx_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_nxt;
    logic             r_req;
    logic             w_req_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_start_rise;
    logic             w_beat;
    logic             w_last;

    assign w_start_rise = start & ~r_start_q;
    assign w_beat       = (r_state == S_XFER) & gnt;
    // len_q is never zero inside a burst, so len_q-1 cannot wrap
    assign w_last       = (r_idx == (r_len_q - LEN_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_len_q    <= '0;
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_start_q  <= start;
            r_len_q    <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_req      <= w_req_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len_q;
        w_idx_nxt   = r_idx;
        w_wait_nxt  = r_wait_cnt;
        w_req_nxt   = r_req;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    if (len != '0) begin
                        w_len_nxt   = len;
                        w_idx_nxt   = '0;
                        w_wait_nxt  = '0;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (gnt) begin
                    w_state_nxt = S_XFER;
                end else if (r_wait_cnt >= WAIT_LAST) begin
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt != 8'hFF) begin
                    w_wait_nxt  = r_wait_cnt + 8'd1;
                end
            end
            S_XFER: begin
                // gnt low here means preemption: stall with req held, no timeout
                if (gnt) begin
                    if (w_last) begin
                        w_req_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_idx_nxt   = r_idx + LEN_W'(1);
                    end
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign req        = r_req;
    assign busy       = (r_state != S_IDLE);
    assign xfer_valid = w_beat;
    assign xfer_idx   = r_idx;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_bus_requester.sv
// Bench for bus_requester: registered one-cycle-latency arbiter model with a
// grant-block input, a negedge beat monitor, and per-scenario scoreboard tasks.
module tb_bus_requester;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             gnt;
    logic             req;
    logic             busy;
    logic             xfer_valid;
    logic [LEN_W-1:0] xfer_idx;
    logic             done;
    logic             err;
    logic             blk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int done_cyc = -1;
    int err_cyc = -1;
    int req_rise_cyc = -1;
    logic req_d = 1'b0;
    logic req_at_done = 1'b0;
    int exp_q[$];
    int obs_q[$];
    int beat_cyc[$];

    always #5 clk = ~clk;

    bus_requester #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .gnt        (gnt),
        .req        (req),
        .busy       (busy),
        .xfer_valid (xfer_valid),
        .xfer_idx   (xfer_idx),
        .done       (done),
        .err        (err)
    );

    // Arbiter stand-in: grant is req delayed one clock, forced low while blk
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gnt <= 1'b0;
        else        gnt <= req & ~blk;
    end

    always @(negedge clk) begin
        cyc++;
        if (xfer_valid) begin
            obs_q.push_back(int'(xfer_idx));
            beat_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            req_at_done = req;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (done && err) both_cnt++;
        if (req && !req_d) req_rise_cyc = cyc;
        req_d = req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        exp_q.delete();
        obs_q.delete();
        beat_cyc.delete();
        done_cnt = 0;
        err_cnt = 0;
        done_cyc = -1;
        err_cyc = -1;
        req_rise_cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        blk   = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({req, busy, xfer_valid, done, err, xfer_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: req=%b busy=%b xv=%b done=%b err=%b idx=%0d, required all 0",
                     req, busy, xfer_valid, done, err, xfer_idx);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({req, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release_idle: req=%b busy=%b, required 0 0", req, busy);
        end
    endtask

    task automatic test_basic();
        int c0;
        int t;
        int e;
        int o;
        clear();
        len = 4'd3;
        start = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 3; i++) exp_q.push_back(i);
        tick();
        start = 1'b0;
        n_cmp++;
        if (req !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_req_rise: req=%b, required 1", req);
        end
        t = 0;
        while (busy && t < 50) begin
            tick();
            t++;
        end
        n_cmp++;
        if (t >= 50) begin n_bad++; $display("FAIL basic_wait: busy stuck, required idle"); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_beat_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL basic_idx: got %0d, required %0d", o, e); end
        end
        n_cmp++;
        if (beat_cyc.size() != 3 || beat_cyc[0] != c0 + 3 || beat_cyc[2] != c0 + 5) begin
            n_bad++;
            $display("FAIL basic_beat_timing: first=%0d last=%0d, required %0d %0d",
                     beat_cyc[0], beat_cyc[beat_cyc.size()-1], c0 + 3, c0 + 5);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != c0 + 6) begin
            n_bad++;
            $display("FAIL basic_done: count=%0d cyc=%0d, required 1 at %0d", done_cnt, done_cyc, c0 + 6);
        end
        n_cmp++;
        if (req_at_done !== 1'b0) begin n_bad++; $display("FAIL basic_req_at_done: req=%b, required 0", req_at_done); end
        n_cmp++;
        if (cyc != done_cyc + 1) begin
            n_bad++;
            $display("FAIL basic_busy_fall: busy low at %0d, required %0d", cyc, done_cyc + 1);
        end
    endtask

    task automatic test_stall();
        int c0;
        int t;
        int s0;
        int e;
        int o;
        clear();
        len = 4'd4;
        start = 1'b1;
        c0 = cyc;
        s0 = -10;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        tick();
        start = 1'b0;
        t = 0;
        while (busy && t < 60) begin
            tick();
            t++;
            if (cyc == s0 + 1 || cyc == s0 + 2) begin
                n_cmp++;
                if (xfer_valid !== 1'b0 || req !== 1'b1 || xfer_idx !== 4'd2) begin
                    n_bad++;
                    $display("FAIL stall_hold: xv=%b req=%b idx=%0d, required 0 1 2", xfer_valid, req, xfer_idx);
                end
                if (cyc == s0 + 2) blk = 1'b0;
            end else if (s0 < 0 && obs_q.size() == 2) begin
                blk = 1'b1;
                s0 = cyc;
            end
        end
        blk = 1'b0;
        n_cmp++;
        if (t >= 60) begin n_bad++; $display("FAIL stall_wait: busy stuck, required idle"); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL stall_beat_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL stall_idx: got %0d, required %0d", o, e); end
        end
        n_cmp++;
        if (beat_cyc.size() != 4 || beat_cyc[2] - beat_cyc[1] != 3) begin
            n_bad++;
            $display("FAIL stall_gap: beat spacing %0d, required 3", beat_cyc[2] - beat_cyc[1]);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != c0 + 9) begin
            n_bad++;
            $display("FAIL stall_done: count=%0d cyc=%0d, required 1 at %0d", done_cnt, done_cyc, c0 + 9);
        end
    endtask

    task automatic test_timeout();
        int t;
        clear();
        blk = 1'b1;
        len = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (busy && t < 60) begin
            tick();
            t++;
        end
        tick();
        blk = 1'b0;
        n_cmp++;
        if (t >= 60) begin n_bad++; $display("FAIL timeout_wait: busy stuck, required idle"); end
        n_cmp++;
        if (err_cnt != 1 || err_cyc - req_rise_cyc != TIMEOUT) begin
            n_bad++;
            $display("FAIL timeout_err: count=%0d delay=%0d, required 1 after %0d", err_cnt, err_cyc - req_rise_cyc, TIMEOUT);
        end
        n_cmp++;
        if (req !== 1'b0 || obs_q.size() != 0 || done_cnt != 0) begin
            n_bad++;
            $display("FAIL timeout_side: req=%b beats=%0d done=%0d, required 0 0 0", req, obs_q.size(), done_cnt);
        end
    endtask

    task automatic test_len_zero();
        int c0;
        logic seen;
        clear();
        len = 4'd0;
        start = 1'b1;
        c0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            if (busy || req) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL len0_idle: busy/req seen=%b, required 0", seen); end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != c0 + 1 || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL len0_done: count=%0d cyc=%0d beats=%0d, required 1 at %0d 0", done_cnt, done_cyc, obs_q.size(), c0 + 1);
        end
    endtask

    task automatic test_retrigger();
        int c0;
        int t;
        int e;
        int o;
        logic seen;
        clear();
        len = 4'd5;
        start = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 5; i++) exp_q.push_back(i);
        tick();
        t = 0;
        while (busy && t < 60) begin
            tick();
            t++;
            if (cyc == c0 + 3 || cyc == c0 + 5) start = 1'b0;
            if (cyc == c0 + 4 || cyc == c0 + 6) start = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || req) seen = 1'b1;
        end
        start = 1'b0;
        n_cmp++;
        if (t >= 60) begin n_bad++; $display("FAIL retrig_wait: busy stuck, required idle"); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL retrig_beat_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL retrig_idx: got %0d, required %0d", o, e); end
        end
        n_cmp++;
        if (done_cnt != 1 || seen !== 1'b0) begin
            n_bad++;
            $display("FAIL retrig_single: done=%0d relaunch=%b, required 1 0", done_cnt, seen);
        end
    endtask

    task automatic test_async_reset();
        int c0;
        int t;
        int e;
        int o;
        clear();
        len = 4'd6;
        start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(i);
        tick();
        start = 1'b0;
        t = 0;
        while (obs_q.size() < 3 && t < 40) begin
            tick();
            t++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req, busy, xfer_valid} !== 3'b000 || t >= 40) begin
            n_bad++;
            $display("FAIL areset_immediate: req=%b busy=%b xv=%b, required 0 0 0", req, busy, xfer_valid);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (done_cnt != 0 || err_cnt != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_quiet: done=%0d err=%0d busy=%b, required 0 0 0", done_cnt, err_cnt, busy);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL areset_pre_idx: got %0d, required %0d", o, e); end
        end
        clear();
        len = 4'd6;
        start = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 6; i++) exp_q.push_back(i);
        tick();
        start = 1'b0;
        t = 0;
        while (busy && t < 60) begin
            tick();
            t++;
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size() || beat_cyc[0] != c0 + 3) begin
            n_bad++;
            $display("FAIL areset_rerun_count: beats=%0d first=%0d, required %0d at %0d", obs_q.size(), beat_cyc[0], exp_q.size(), c0 + 3);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL areset_rerun_idx: got %0d, required %0d", o, e); end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != c0 + 9) begin
            n_bad++;
            $display("FAIL areset_rerun_done: count=%0d cyc=%0d, required 1 at %0d", done_cnt, done_cyc, c0 + 9);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        tick();
        test_stall();
        tick();
        test_timeout();
        tick();
        test_len_zero();
        test_retrigger();
        tick();
        test_async_reset();
        n_cmp++;
        if (both_cnt != 0) begin n_bad++; $display("FAIL done_err_exclusive: both high %0d times, required 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
